branch_predictor: RTL and testbench

- Branch target buffer (BTB) with 2-bit saturating direction counters.
- Serves the predictor side of the pipeline control unit's predictor interface:
  - IF: combinational lookup on the fetch PC, producing jump_taken_predict and a target for the PC generator.
  - ID: learns unconditional jumps (J/JAL/JR).
  - EX: trains conditional branches (BEQ/BNE) from the resolved outcome.

---
 rtl/branch_predictor_pkg.sv | 15 +
 rtl/branch_predictor_if.sv | 42 ++++
 rtl/bp_sat_cnt.sv | 21 ++
 rtl/branch_predictor.sv | 133 +++++++++++++
 tb/tb_branch_predictor.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: 2-bit direction counter
// encodings and the counter value each kind of new entry starts with.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } cnt_e;

    localparam cnt_e CNT_ALLOC_COND   = CNT_WT;
    localparam cnt_e CNT_ALLOC_UNCOND = CNT_ST;

endpackage

// File: rtl/branch_predictor_if.sv
// Predictor-side interface of the pipeline control unit: IF lookup, ID learn,
// EX training. With BP_STATS_EN defined it also carries the statistics counters.
interface branch_predictor_if #(
    parameter int PC_W = 32
);
    logic [PC_W-1:0] pc_if;
    logic            jump_taken_predict;
    logic [PC_W-1:0] predict_target;
    logic            stall_id;
    logic [PC_W-1:0] pc_id;
    logic            uncond_jump_instr;
    logic [PC_W-1:0] uncond_target_id;
    logic            cond_jump_instr;
    logic [PC_W-1:0] cond_target_id;
    logic            cond_jump_predict_fail_ex;
    logic            cond_jump_taken_ex;
`ifdef BP_STATS_EN
    logic [31:0]     bp_cond_cnt;
    logic [31:0]     bp_miss_cnt;
`endif

    modport master (
`ifdef BP_STATS_EN
        input  bp_cond_cnt, bp_miss_cnt,
`endif
        input  jump_taken_predict, predict_target,
        output pc_if, stall_id, pc_id, uncond_jump_instr, uncond_target_id,
               cond_jump_instr, cond_target_id, cond_jump_predict_fail_ex,
               cond_jump_taken_ex
    );

    modport slave (
`ifdef BP_STATS_EN
        output bp_cond_cnt, bp_miss_cnt,
`endif
        output jump_taken_predict, predict_target,
        input  pc_if, stall_id, pc_id, uncond_jump_instr, uncond_target_id,
               cond_jump_instr, cond_target_id, cond_jump_predict_fail_ex,
               cond_jump_taken_ex
    );

endinterface

// File: rtl/bp_sat_cnt.sv
// Combinational next-state of a 2-bit saturating direction counter.
module bp_sat_cnt
    import branch_predictor_pkg::*;
(
    input  logic taken_i,
    input  cnt_e cnt_i,
    output cnt_e cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        case (cnt_i)
            CNT_SNT: cnt_o = taken_i ? CNT_WNT : CNT_SNT;
            CNT_WNT: cnt_o = taken_i ? CNT_WT  : CNT_SNT;
            CNT_WT:  cnt_o = taken_i ? CNT_ST  : CNT_WNT;
            CNT_ST:  cnt_o = taken_i ? CNT_ST  : CNT_WT;
            default: cnt_o = cnt_i;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: combinational IF lookup,
// ID learning of unconditional jumps, EX training of conditional branches.
// Optional statistics counters are built when BP_STATS_EN is defined.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int BTB_DEPTH = 16,
    parameter int PC_W      = 32
) (
    input logic               clk,
    input logic               rst,
    branch_predictor_if.slave bp
);
    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = PC_W - IDX_W - 2;

    logic [BTB_DEPTH-1:0]            valid_q, valid_d;
    logic [BTB_DEPTH-1:0]            uncond_q, uncond_d;
    logic [BTB_DEPTH-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [BTB_DEPTH-1:0][PC_W-1:0]  target_q, target_d;
    logic [BTB_DEPTH-1:0][1:0]       cnt_q, cnt_d;

    logic            ex_vld_q, ex_vld_d;
    logic [PC_W-1:0] ex_pc_q, ex_pc_d;
    logic [PC_W-1:0] ex_tgt_q, ex_tgt_d;

    logic [IDX_W-1:0] if_idx, id_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, id_tag, ex_tag;
    logic             if_hit, ex_hit, id_we, ex_we;
    cnt_e             ex_cnt_nxt;

    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{bp.pc_if[1:0], bp.pc_id[1:0], ex_pc_q[1:0]};

    assign if_idx = bp.pc_if[IDX_W+1:2];
    assign if_tag = bp.pc_if[PC_W-1:IDX_W+2];
    assign id_idx = bp.pc_id[IDX_W+1:2];
    assign id_tag = bp.pc_id[PC_W-1:IDX_W+2];
    assign ex_idx = ex_pc_q[IDX_W+1:2];
    assign ex_tag = ex_pc_q[PC_W-1:IDX_W+2];

    // No write bypass: a lookup in the write cycle sees the old entry.
    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign bp.jump_taken_predict = if_hit && (uncond_q[if_idx] || cnt_q[if_idx][1]);
    assign bp.predict_target     = if_hit ? target_q[if_idx] : '0;

    // An uncond entry aliasing the branch tag is treated as a miss.
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag) && !uncond_q[ex_idx];
    assign ex_we  = ex_vld_q && (ex_hit || bp.cond_jump_taken_ex);
    assign id_we  = bp.uncond_jump_instr && !bp.stall_id && !bp.cond_jump_predict_fail_ex;

    bp_sat_cnt u_sat_cnt (
        .taken_i (bp.cond_jump_taken_ex),
        .cnt_i   (cnt_e'(cnt_q[ex_idx])),
        .cnt_o   (ex_cnt_nxt)
    );

    always_comb begin
        valid_d  = valid_q;
        uncond_d = uncond_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        ex_vld_d = bp.cond_jump_instr && !bp.stall_id && !bp.cond_jump_predict_fail_ex;
        ex_pc_d  = bp.pc_id;
        ex_tgt_d = bp.cond_target_id;
        if (id_we) begin
            valid_d[id_idx]  = 1'b1;
            uncond_d[id_idx] = 1'b1;
            tag_d[id_idx]    = id_tag;
            target_d[id_idx] = bp.uncond_target_id;
            cnt_d[id_idx]    = CNT_ALLOC_UNCOND;
        end
        // Applied after the ID write so the EX update wins a same-index collision.
        if (ex_we) begin
            valid_d[ex_idx]  = 1'b1;
            uncond_d[ex_idx] = 1'b0;
            tag_d[ex_idx]    = ex_tag;
            target_d[ex_idx] = ex_tgt_q;
            cnt_d[ex_idx]    = ex_hit ? ex_cnt_nxt : CNT_ALLOC_COND;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= '0;
            uncond_q <= '0;
            tag_q    <= '0;
            target_q <= '0;
            cnt_q    <= '0;
            ex_vld_q <= 1'b0;
            ex_pc_q  <= '0;
            ex_tgt_q <= '0;
        end else begin
            valid_q  <= valid_d;
            uncond_q <= uncond_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            ex_vld_q <= ex_vld_d;
            ex_pc_q  <= ex_pc_d;
            ex_tgt_q <= ex_tgt_d;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] cond_cnt_q, cond_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        cond_cnt_d = cond_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (ex_vld_q) begin
            cond_cnt_d = cond_cnt_q + 32'd1;
            if (bp.cond_jump_predict_fail_ex) miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cond_cnt_q <= '0;
            miss_cnt_q <= '0;
        end else begin
            cond_cnt_q <= cond_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign bp.bp_cond_cnt = cond_cnt_q;
    assign bp.bp_miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (BTB_DEPTH=16, PC_W=32).
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    branch_predictor_if #(.PC_W(32)) bp_if ();

    branch_predictor #(.BTB_DEPTH(16), .PC_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp_if.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic look(input logic [31:0] pc);
        bp_if.pc_if = pc;
        #1;
    endtask

    // Branch enters ID one cycle, resolves in EX the next.
    task automatic cond_br(input logic [31:0] pc, input logic [31:0] tgt,
                           input logic taken, input logic fail);
        bp_if.cond_jump_instr = 1'b1;
        bp_if.pc_id           = pc;
        bp_if.cond_target_id  = tgt;
        step();
        bp_if.cond_jump_instr           = 1'b0;
        bp_if.cond_jump_taken_ex        = taken;
        bp_if.cond_jump_predict_fail_ex = fail;
        step();
        bp_if.cond_jump_taken_ex        = 1'b0;
        bp_if.cond_jump_predict_fail_ex = 1'b0;
    endtask

    task automatic uncond_id(input logic [31:0] pc, input logic [31:0] tgt,
                             input logic stall, input logic fail);
        bp_if.uncond_jump_instr         = 1'b1;
        bp_if.pc_id                     = pc;
        bp_if.uncond_target_id          = tgt;
        bp_if.stall_id                  = stall;
        bp_if.cond_jump_predict_fail_ex = fail;
        step();
        bp_if.uncond_jump_instr         = 1'b0;
        bp_if.stall_id                  = 1'b0;
        bp_if.cond_jump_predict_fail_ex = 1'b0;
    endtask

    initial begin
        bp_if.pc_if                     = '0;
        bp_if.stall_id                  = 1'b0;
        bp_if.pc_id                     = '0;
        bp_if.uncond_jump_instr         = 1'b0;
        bp_if.uncond_target_id          = '0;
        bp_if.cond_jump_instr           = 1'b0;
        bp_if.cond_target_id            = '0;
        bp_if.cond_jump_predict_fail_ex = 1'b0;
        bp_if.cond_jump_taken_ex        = 1'b0;

        // Reset
        step(); step();
        rst = 1'b0;
        look(32'h0040_0010);
        chk("reset_pred", bp_if.jump_taken_predict, 32'd0);
        chk("reset_tgt",  bp_if.predict_target,     32'd0);

        // Unconditional learn
        uncond_id(32'h0040_0020, 32'h0040_0100, 1'b0, 1'b0);
        look(32'h0040_0020);
        chk("uncond_pred", bp_if.jump_taken_predict, 32'd1);
        chk("uncond_tgt",  bp_if.predict_target,     32'h0040_0100);

        // Stalled ID creates nothing
        uncond_id(32'h0040_0030, 32'h0040_0110, 1'b1, 1'b0);
        look(32'h0040_0030);
        chk("stall_pred", bp_if.jump_taken_predict, 32'd0);
        chk("stall_tgt",  bp_if.predict_target,     32'd0);

        // Conditional training at 0x00400040
        cond_br(32'h0040_0040, 32'h0040_0080, 1'b1, 1'b0);
        look(32'h0040_0040);
        chk("cond_alloc_pred", bp_if.jump_taken_predict, 32'd1);
        chk("cond_alloc_tgt",  bp_if.predict_target,     32'h0040_0080);
        cond_br(32'h0040_0040, 32'h0040_0080, 1'b0, 1'b0);
        chk("cond_wnt_pred", bp_if.jump_taken_predict, 32'd0);
        cond_br(32'h0040_0040, 32'h0040_0080, 1'b0, 1'b0);
        chk("cond_snt_pred", bp_if.jump_taken_predict, 32'd0);
        chk("cond_snt_tgt",  bp_if.predict_target,     32'h0040_0080);
        cond_br(32'h0040_0040, 32'h0040_0080, 1'b0, 1'b0);
        cond_br(32'h0040_0040, 32'h0040_0080, 1'b1, 1'b0);
        chk("cond_floor_pred", bp_if.jump_taken_predict, 32'd0);
        cond_br(32'h0040_0040, 32'h0040_0080, 1'b1, 1'b0);
        chk("cond_wt_pred", bp_if.jump_taken_predict, 32'd1);
        cond_br(32'h0040_0040, 32'h0040_0080, 1'b1, 1'b0);
        chk("cond_st_pred", bp_if.jump_taken_predict, 32'd1);
        cond_br(32'h0040_0040, 32'h0040_0080, 1'b0, 1'b0);
        chk("cond_st_down_pred", bp_if.jump_taken_predict, 32'd1);
        cond_br(32'h0040_0040, 32'h0040_0080, 1'b0, 1'b0);
        chk("cond_wt_down_pred", bp_if.jump_taken_predict, 32'd0);

        // Not-taken on a fresh miss allocates nothing
        cond_br(32'h0040_0048, 32'h0040_0090, 1'b0, 1'b0);
        look(32'h0040_0048);
        chk("nt_miss_pred", bp_if.jump_taken_predict, 32'd0);
        chk("nt_miss_tgt",  bp_if.predict_target,     32'd0);

        // Wrong-path uncond suppressed
        uncond_id(32'h0040_0200, 32'h0040_0300, 1'b0, 1'b1);
        look(32'h0040_0200);
        chk("wrongpath_pred", bp_if.jump_taken_predict, 32'd0);
        chk("wrongpath_tgt",  bp_if.predict_target,     32'd0);
        look(32'h0040_0040);
        chk("wrongpath_keep_tgt", bp_if.predict_target, 32'h0040_0080);

        // Same-index collision: EX 0x00400044 vs ID 0x00400084 (index 1)
        bp_if.cond_jump_instr = 1'b1;
        bp_if.pc_id           = 32'h0040_0044;
        bp_if.cond_target_id  = 32'h0040_0500;
        step();
        bp_if.cond_jump_instr    = 1'b0;
        bp_if.cond_jump_taken_ex = 1'b1;
        bp_if.uncond_jump_instr  = 1'b1;
        bp_if.pc_id              = 32'h0040_0084;
        bp_if.uncond_target_id   = 32'h0040_0600;
        step();
        bp_if.cond_jump_taken_ex = 1'b0;
        bp_if.uncond_jump_instr  = 1'b0;
        look(32'h0040_0044);
        chk("collide_ex_pred", bp_if.jump_taken_predict, 32'd1);
        chk("collide_ex_tgt",  bp_if.predict_target,     32'h0040_0500);
        look(32'h0040_0084);
        chk("collide_id_pred", bp_if.jump_taken_predict, 32'd0);

        // Read during write returns old contents
        look(32'h0040_0058);
        bp_if.uncond_jump_instr = 1'b1;
        bp_if.pc_id             = 32'h0040_0058;
        bp_if.uncond_target_id  = 32'h0040_0700;
        #1;
        chk("rdw_old_pred", bp_if.jump_taken_predict, 32'd0);
        step();
        bp_if.uncond_jump_instr = 1'b0;
        #1;
        chk("rdw_new_pred", bp_if.jump_taken_predict, 32'd1);
        chk("rdw_new_tgt",  bp_if.predict_target,     32'h0040_0700);

        // Reset mid-operation discards the pending capture
        bp_if.cond_jump_instr = 1'b1;
        bp_if.pc_id           = 32'h0040_004C;
        bp_if.cond_target_id  = 32'h0040_0800;
        step();
        bp_if.cond_jump_instr    = 1'b0;
        bp_if.cond_jump_taken_ex = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        bp_if.cond_jump_taken_ex = 1'b0;
        look(32'h0040_004C);
        chk("rst_mid_pred", bp_if.jump_taken_predict, 32'd0);
        look(32'h0040_0058);
        chk("rst_clear_pred", bp_if.jump_taken_predict, 32'd0);
        chk("rst_clear_tgt",  bp_if.predict_target,     32'd0);

`ifdef BP_STATS_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("stats_rst_cond", bp_if.bp_cond_cnt, 32'd0);
        chk("stats_rst_miss", bp_if.bp_miss_cnt, 32'd0);
        cond_br(32'h0040_0060, 32'h0040_0900, 1'b1, 1'b0);
        cond_br(32'h0040_0060, 32'h0040_0900, 1'b0, 1'b1);
        cond_br(32'h0040_0064, 32'h0040_0904, 1'b1, 1'b0);
        cond_br(32'h0040_0068, 32'h0040_0908, 1'b1, 1'b1);
        cond_br(32'h0040_0060, 32'h0040_0900, 1'b0, 1'b0);
        chk("stats_cond", bp_if.bp_cond_cnt, 32'd5);
        chk("stats_miss", bp_if.bp_miss_cnt, 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("stats_rst2_cond", bp_if.bp_cond_cnt, 32'd0);
        chk("stats_rst2_miss", bp_if.bp_miss_cnt, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
